// File: rtl/irq_pkg.sv
// Shared constants, state encoding and helpers for the 16-source interrupt controller.
package irq_pkg;

    localparam int N_SRC = 16;
    localparam int ID_W  = 4;

    localparam logic [N_SRC-1:0] MASK_RST    = 16'h0000;
    localparam logic [N_SRC-1:0] PENDING_RST = 16'h0000;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } irq_state_e;

    function automatic logic [N_SRC-1:0] onehot_f(input logic [ID_W-1:0] id);
        onehot_f = {{(N_SRC-1){1'b0}}, 1'b1} << id;
    endfunction

endpackage

// File: rtl/prio_enc_16.sv
// Combinational 16-to-4 priority encoder; the highest set index wins.
module prio_enc_16
    import irq_pkg::*;
(
    input  logic [N_SRC-1:0] vec_i,
    output logic [ID_W-1:0]  id_o,
    output logic             any_o
);

    // Ascending scan so that later (higher) indices overwrite lower ones.
    always_comb begin
        id_o  = {ID_W{1'b0}};
        any_o = 1'b0;
        for (int i = 0; i < N_SRC; i++) begin
            if (vec_i[i]) begin
                id_o  = ID_W'(i);
                any_o = 1'b1;
            end else begin
                id_o  = id_o;
                any_o = any_o;
            end
        end
    end

endmodule

// File: rtl/irq_ctrl_16.sv
// Interrupt controller: edge capture into pending, masking, and a valid/ack
// handshake presenting the highest eligible source ID.
module irq_ctrl_16
    import irq_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] req,
    input  logic             en,
    input  logic             mask_we,
    input  logic [N_SRC-1:0] mask_wdata,
    input  logic             irq_ack,
    output logic             irq_valid,
    output logic [ID_W-1:0]  irq_id,
    output logic [N_SRC-1:0] pending,
    output logic [N_SRC-1:0] mask,
    output logic             lost
);

    irq_state_e       state_q, state_d;
    logic [N_SRC-1:0] req_q;
    logic [N_SRC-1:0] pending_q, pending_d;
    logic [N_SRC-1:0] mask_q, mask_d;
    logic             lost_q, lost_d;
    logic [ID_W-1:0]  irq_id_q, irq_id_d;

    logic [N_SRC-1:0] rise_s;
    logic [N_SRC-1:0] clr_s;
    logic [N_SRC-1:0] elig_s;
    logic [ID_W-1:0]  top_s;
    logic             any_s;

    assign rise_s = req & ~req_q;
    assign elig_s = pending_q & mask_q;

    prio_enc_16 u_prio_enc (
        .vec_i (elig_s),
        .id_o  (top_s),
        .any_o (any_s)
    );

    // Handshake FSM; the presented ID is frozen until ack or disable.
    always_comb begin
        state_d  = state_q;
        irq_id_d = irq_id_q;
        clr_s    = {N_SRC{1'b0}};
        case (state_q)
            IDLE: begin
                if (en && any_s) begin
                    irq_id_d = top_s;
                    state_d  = PRESENT;
                end else begin
                    state_d  = IDLE;
                end
            end
            PRESENT: begin
                if (irq_ack) begin
                    clr_s   = onehot_f(irq_id_q);
                    state_d = IDLE;
                end else if (!en) begin
                    state_d = IDLE;
                end else begin
                    state_d = PRESENT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Pending/mask/lost next state; a new edge beats a same-cycle clear.
    always_comb begin
        pending_d = (pending_q & ~clr_s) | rise_s;
        lost_d    = lost_q | (|(rise_s & pending_q & ~clr_s));
        if (mask_we) begin
            mask_d = mask_wdata;
        end else begin
            mask_d = mask_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            req_q     <= {N_SRC{1'b0}};
            pending_q <= PENDING_RST;
            mask_q    <= MASK_RST;
            lost_q    <= 1'b0;
            irq_id_q  <= {ID_W{1'b0}};
        end else begin
            state_q   <= state_d;
            req_q     <= req;
            pending_q <= pending_d;
            mask_q    <= mask_d;
            lost_q    <= lost_d;
            irq_id_q  <= irq_id_d;
        end
    end

    assign irq_valid = (state_q == PRESENT);
    assign irq_id    = irq_id_q;
    assign pending   = pending_q;
    assign mask      = mask_q;
    assign lost      = lost_q;

endmodule

// File: tb/tb_irq_ctrl_16.sv
// Directed self-checking bench for irq_ctrl_16 with hand-computed expectations.
module tb_irq_ctrl_16;

    logic        clk;
    logic        rst;
    logic [15:0] req;
    logic        en;
    logic        mask_we;
    logic [15:0] mask_wdata;
    logic        irq_ack;
    logic        irq_valid;
    logic [3:0]  irq_id;
    logic [15:0] pending;
    logic [15:0] mask;
    logic        lost;

    int total;
    int bad;

    irq_ctrl_16 dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .en         (en),
        .mask_we    (mask_we),
        .mask_wdata (mask_wdata),
        .irq_ack    (irq_ack),
        .irq_valid  (irq_valid),
        .irq_id     (irq_id),
        .pending    (pending),
        .mask       (mask),
        .lost       (lost)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic write_mask(input logic [15:0] m);
        mask_we    = 1'b1;
        mask_wdata = m;
        tick();
        mask_we    = 1'b0;
    endtask

    task automatic do_ack();
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        rst        = 1'b1;
        req        = 16'h0000;
        en         = 1'b1;
        mask_we    = 1'b0;
        mask_wdata = 16'h0000;
        irq_ack    = 1'b0;
        tick();
        tick();
        chk("rst_pending", pending, 16'h0000);
        chk("rst_mask",    mask,    16'h0000);
        chk("rst_lost",    {15'd0, lost},      16'h0000);
        chk("rst_valid",   {15'd0, irq_valid}, 16'h0000);
        chk("rst_id",      {12'd0, irq_id},    16'h0000);
        rst = 1'b0;

        write_mask(16'hFFFF);
        chk("mask_ffff", mask, 16'hFFFF);

        // single source, two-cycle latency
        req = 16'h0020;
        tick();
        req = 16'h0000;
        chk("t1_pend",   pending, 16'h0020);
        chk("t1_valid0", {15'd0, irq_valid}, 16'h0000);
        tick();
        chk("t1_valid1", {15'd0, irq_valid}, 16'h0001);
        chk("t1_id",     {12'd0, irq_id},    16'h0005);
        do_ack();
        chk("t1_pend_clr", pending, 16'h0000);
        chk("t1_valid_clr", {15'd0, irq_valid}, 16'h0000);

        // simultaneous 3 and 12, then 15 arriving during grant of 3
        req = 16'h1008;
        tick();
        req = 16'h0000;
        chk("t2_pend", pending, 16'h1008);
        tick();
        chk("t2_id12", {12'd0, irq_id}, 16'h000C);
        do_ack();
        chk("t2_pend_after", pending, 16'h0008);
        chk("t2_idle_gap",   {15'd0, irq_valid}, 16'h0000);
        tick();
        chk("t2_valid3", {15'd0, irq_valid}, 16'h0001);
        chk("t2_id3",    {12'd0, irq_id},    16'h0003);
        req = 16'h8000;
        tick();
        req = 16'h0000;
        chk("t3_pend",  pending, 16'h8008);
        chk("t3_hold3", {12'd0, irq_id}, 16'h0003);
        tick();
        chk("t3_hold3b", {12'd0, irq_id}, 16'h0003);
        do_ack();
        chk("t3_pend_after", pending, 16'h8000);
        tick();
        chk("t3_id15", {12'd0, irq_id}, 16'h000F);
        chk("t3_valid15", {15'd0, irq_valid}, 16'h0001);
        do_ack();
        chk("t3_pend_clr", pending, 16'h0000);

        // masked source, then unmasked by a mask write
        write_mask(16'h00FF);
        req = 16'h0200;
        tick();
        req = 16'h0000;
        chk("t4_pend", pending, 16'h0200);
        tick();
        tick();
        chk("t4_masked", {15'd0, irq_valid}, 16'h0000);
        write_mask(16'h0200);
        chk("t4_mask", mask, 16'h0200);
        chk("t4_valid_k", {15'd0, irq_valid}, 16'h0000);
        tick();
        chk("t4_valid", {15'd0, irq_valid}, 16'h0001);
        chk("t4_id9",   {12'd0, irq_id},    16'h0009);
        do_ack();
        chk("t4_pend_clr", pending, 16'h0000);

        // ack coinciding with a new edge on the same source
        write_mask(16'hFFFF);
        req = 16'h0004;
        tick();
        req = 16'h0000;
        tick();
        chk("t5_id2", {12'd0, irq_id}, 16'h0002);
        irq_ack = 1'b1;
        req     = 16'h0004;
        tick();
        irq_ack = 1'b0;
        req     = 16'h0000;
        chk("t5_setwins", pending, 16'h0004);
        chk("t5_nolost",  {15'd0, lost}, 16'h0000);
        chk("t5_gap",     {15'd0, irq_valid}, 16'h0000);
        tick();
        chk("t5_re_id2", {12'd0, irq_id}, 16'h0002);
        // second edge while still pending sets lost
        req = 16'h0004;
        tick();
        req = 16'h0000;
        chk("t5_lost", {15'd0, lost}, 16'h0001);
        chk("t5_pend", pending, 16'h0004);
        do_ack();
        chk("t5_pend_clr", pending, 16'h0000);
        chk("t5_lost_sticky", {15'd0, lost}, 16'h0001);

        // disable while presenting, then re-enable
        req = 16'h0080;
        tick();
        req = 16'h0000;
        tick();
        chk("t6_id7", {12'd0, irq_id}, 16'h0007);
        en = 1'b0;
        tick();
        chk("t6_en_off_valid", {15'd0, irq_valid}, 16'h0000);
        chk("t6_en_off_pend",  pending, 16'h0080);
        tick();
        chk("t6_en_off_hold", {15'd0, irq_valid}, 16'h0000);
        en = 1'b1;
        tick();
        chk("t6_re_valid", {15'd0, irq_valid}, 16'h0001);
        chk("t6_re_id7",   {12'd0, irq_id},    16'h0007);

        // reset mid-handshake with req[1] held high across release
        rst = 1'b1;
        req = 16'h0002;
        tick();
        chk("t7_pending", pending, 16'h0000);
        chk("t7_mask",    mask,    16'h0000);
        chk("t7_lost",    {15'd0, lost},      16'h0000);
        chk("t7_valid",   {15'd0, irq_valid}, 16'h0000);
        chk("t7_id",      {12'd0, irq_id},    16'h0000);
        rst = 1'b0;
        tick();
        chk("t7_held_edge", pending, 16'h0002);
        tick();
        chk("t7_held_once", pending, 16'h0002);
        chk("t7_masked_valid", {15'd0, irq_valid}, 16'h0000);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        req     = 16'h0000;
        chk("t7_idle_ack_ignored", pending, 16'h0002);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
